// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin arbiter in front of an 8N1 serializer.
// A grant is held until a last byte, MaxHold bytes, or IdleTimeout idle clocks.
module uart_tx_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned ClockFrequency = 30_000_000,
    parameter int unsigned BaudRate       = 921_600,
    parameter int unsigned MaxHold        = 64,
    parameter int unsigned IdleTimeout    = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumReq-1:0]   req_valid_i,
    input  logic [NumReq*8-1:0] req_data_i,
    input  logic [NumReq-1:0]   req_last_i,
    output logic [NumReq-1:0]   req_ready_o,
    output logic [NumReq-1:0]   grant_o,
    output logic                tx_o,
    output logic                busy_o
);
    localparam int unsigned ClksPerBit = ClockFrequency / BaudRate;
    localparam int unsigned BaudW      = $clog2(ClksPerBit);
    localparam int unsigned IdxW       = $clog2(NumReq);
    localparam int unsigned ByteW      = $clog2(MaxHold + 1);
    localparam int unsigned IdleW      = $clog2(IdleTimeout + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            st_q, st_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic              owned_q, owned_d;
    logic [NumReq-1:0] grant_q, grant_d;
    logic [7:0]        byte_q, byte_d;
    logic              last_q, last_d;
    logic [2:0]        bit_q, bit_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [ByteW-1:0]  nbytes_q, nbytes_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic              tx_q, tx_d;

    logic [NumReq-1:0] ready;
    logic              found;
    logic [IdxW-1:0]   pick;
    logic [IdxW-1:0]   cand;
    logic [IdxW-1:0]   sel;
    logic [IdxW-1:0]   owner_inc;
    logic              accept;
    logic              baud_end;
    logic              rel;

    // Round-robin search: first valid requester at or after the rr pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        cand  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = IdxW'((32'(rr_q) + i) % NumReq);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state logic for arbitration, grant bookkeeping and the serializer.
    always_comb begin
        st_d      = st_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        owned_d   = owned_q;
        grant_d   = grant_q;
        byte_d    = byte_q;
        last_d    = last_q;
        bit_d     = bit_q;
        baud_d    = baud_q;
        nbytes_d  = nbytes_q;
        idle_d    = idle_q;
        tx_d      = tx_q;
        ready     = '0;
        rel       = 1'b0;
        owner_inc = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + IdxW'(1);
        baud_end  = (baud_q == BaudW'(ClksPerBit - 1));
        // While owned only the owner is eligible.
        sel       = owned_q ? owner_q : pick;
        accept    = owned_q ? req_valid_i[owner_q] : found;

        unique case (st_q)
            StIdle: begin
                if (accept) begin
                    ready[sel] = 1'b1;
                    byte_d     = req_data_i[32'(sel) * 8 +: 8];
                    last_d     = req_last_i[sel];
                    idle_d     = '0;
                    st_d       = StStart;
                    tx_d       = 1'b0;
                    baud_d     = '0;
                    bit_d      = '0;
                    if (!owned_q) begin
                        owner_d    = pick;
                        owned_d    = 1'b1;
                        grant_d    = '0;
                        grant_d[pick] = 1'b1;
                        nbytes_d   = ByteW'(1);
                    end else begin
                        nbytes_d = nbytes_q + ByteW'(1);
                    end
                end else if (owned_q) begin
                    if (idle_q == IdleW'(IdleTimeout - 1)) begin
                        rel = 1'b1;
                    end else begin
                        idle_d = idle_q + IdleW'(1);
                    end
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d = '0;
                    st_d   = StData;
                    tx_d   = byte_q[0];
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        st_d = StStop;
                        tx_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = byte_q[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    st_d   = StIdle;
                    rel    = last_q || (nbytes_q == ByteW'(MaxHold));
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: st_d = StIdle;
        endcase

        if (rel) begin
            owned_d = 1'b0;
            grant_d = '0;
            rr_d    = owner_inc;
            idle_d  = '0;
        end
    end

    // State registers with synchronous reset; reset truncates any frame in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q     <= StIdle;
            owner_q  <= '0;
            rr_q     <= '0;
            owned_q  <= 1'b0;
            grant_q  <= '0;
            byte_q   <= '0;
            last_q   <= 1'b0;
            bit_q    <= '0;
            baud_q   <= '0;
            nbytes_q <= '0;
            idle_q   <= '0;
            tx_q     <= 1'b1;
        end else begin
            st_q     <= st_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            owned_q  <= owned_d;
            grant_q  <= grant_d;
            byte_q   <= byte_d;
            last_q   <= last_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            nbytes_q <= nbytes_d;
            idle_q   <= idle_d;
            tx_q     <= tx_d;
        end
    end

    // Ready is held low while reset is asserted so no byte is lost to a reset cycle.
    assign req_ready_o = rst_i ? '0 : ready;
    assign grant_o     = grant_q;
    assign tx_o        = tx_q;
    assign busy_o      = (st_q != StIdle);

endmodule
